// File: rtl/byte_serial_add_ctrl.sv
// Multi-byte add/subtract that time-shares one 8-bit adder over NBYTES cycles.
// Define BSA_SUB_EN to honour op (subtract as A + ~B + 1).
module byte_serial_add_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  cin,
   input  logic                  op,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   i_q, i_d;
   logic            c_q, c_d;
   logic [W-1:0]    ra_q, ra_d;
   logic [W-1:0]    rb_q, rb_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;

   logic [W-1:0]    b_in;
   logic            c_in;
   logic [8:0]      add;

`ifdef BSA_SUB_EN
   assign b_in = op ? ~b : b;
   assign c_in = op ? 1'b1 : cin;
`else
   logic unused_op;
   assign b_in      = b;
   assign c_in      = cin;
   assign unused_op = op;
`endif

   // The single shared 8-bit ripple adder slice.
   assign add = {1'b0, ra_q[8*i_q +: 8]}
              + {1'b0, rb_q[8*i_q +: 8]}
              + {8'd0, c_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         c_q     <= 1'b0;
         ra_q    <= '0;
         rb_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         c_q     <= c_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      c_d     = c_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b_in;
               c_d     = c_in;
               i_d     = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d[8*i_q +: 8] = add[7:0];
            c_d = add[8];
            i_d = i_q + IW'(1);
            if (i_q == LAST) begin
               cout_d  = add[8];
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ready = (state_q == IDLE) || (state_q == DONE);
   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Randomized and directed bench for byte_serial_add_ctrl (NBYTES=4 and 2)
// against an arithmetic reference model.
module tb_byte_serial_add_ctrl;

   logic clk;
   logic rst_n;

   logic        start, cin, op;
   logic [31:0] a, b;
   logic        ready, busy, done, cout;
   logic [31:0] sum;

   logic        start2, cin2, op2;
   logic [15:0] a2, b2;
   logic        ready2, busy2, done2, cout2;
   logic [15:0] sum2;

   int total = 0;
   int bad   = 0;

   byte_serial_add_ctrl #(.NBYTES(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .cin(cin), .op(op), .ready(ready), .busy(busy), .done(done),
      .sum(sum), .cout(cout)
   );

   byte_serial_add_ctrl #(.NBYTES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
      .cin(cin2), .op(op2), .ready(ready2), .busy(busy2), .done(done2),
      .sum(sum2), .cout(cout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {cout, sum} from plain unsigned arithmetic.
   function automatic logic [32:0] model(input logic [31:0] ma,
                                         input logic [31:0] mb,
                                         input logic mc, input logic mo);
      logic [32:0] r;
      r = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
`ifdef BSA_SUB_EN
      if (mo) begin
         r[31:0] = ma - mb;
         r[32]   = (ma >= mb);
      end
`endif
      return r;
   endfunction

   task automatic wait_done(input string tag, output int cyc);
      cyc = 1;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_lat"}, 64'(cyc), 64'd5);
   endtask

   task automatic run_op(input string tag, input logic [31:0] ta,
                         input logic [31:0] tb2, input logic tc,
                         input logic to);
      logic [32:0] e;
      int cyc;
      e = model(ta, tb2, tc, to);
      start = 1'b1; a = ta; b = tb2; cin = tc; op = to;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      cin = 1'($urandom); op = 1'($urandom);
      wait_done(tag, cyc);
      chk({tag, "_sum"}, 64'(sum), 64'(e[31:0]));
      chk({tag, "_cout"}, 64'(cout), 64'(e[32]));
      chk({tag, "_rdy"}, 64'(ready), 64'd1);
      @(posedge clk); #1;
      chk({tag, "_dpw"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [32:0] e1, e2;
      int cyc;
      rst_n = 1'b0;
      start = 0; a = 0; b = 0; cin = 0; op = 0;
      start2 = 0; a2 = 0; b2 = 0; cin2 = 0; op2 = 0;
      #12;
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
`ifdef BSA_SUB_EN
      run_op("sub1", 32'h5, 32'h7, 1'b0, 1'b1);
      run_op("sub2", 32'h1234_5678, 32'h0234_5678, 1'b1, 1'b1);
`endif

      // start pulse during RUN must be ignored
      start = 1'b1; a = 32'h10; b = 32'h20; cin = 0; op = 0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("ign_busy1", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("ign_busy2", 64'(busy), 64'd1);
      start = 1'b1; a = 32'hAAAA; b = 32'h5555; cin = 1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("ign_busy3", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("ign_busy4", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("ign_done", 64'(done), 64'd1);
      chk("ign_sum", 64'(sum), 64'h30);
      chk("ign_cout", 64'(cout), 64'd0);
      @(posedge clk); #1;
      chk("ign_idle", 64'(busy | done), 64'd0);

      // back-to-back with start held through DONE
      e1 = model(32'hDEAD_BEEF, 32'h1111_2222, 1'b1, 1'b0);
      e2 = model(32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0);
      start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1111_2222; cin = 1; op = 0;
      @(posedge clk); #1;
      a = 32'h8000_0000; b = 32'h8000_0001; cin = 0;
      wait_done("b2b1", cyc);
      chk("b2b1_sum", 64'(sum), 64'(e1[31:0]));
      chk("b2b1_cout", 64'(cout), 64'(e1[32]));
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_done("b2b2", cyc);
      chk("b2b2_sum", 64'(sum), 64'(e2[31:0]));
      chk("b2b2_cout", 64'(cout), 64'(e2[32]));
      @(posedge clk); #1;

      // reset mid-RUN
      start = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1; cin = 0; op = 0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_sum", 64'(sum), 64'd0);
      chk("mrst_cout", 64'(cout), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_ready", 64'(ready), 64'd1);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("post", 32'h1, 32'h1, 1'b0, 1'b0);

      for (int k = 0; k < 30; k++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (k % 5 == 0) ? ra : $urandom;
         run_op("rnd", ra, rb, 1'($urandom), 1'($urandom));
      end

      // two-byte instance
      start2 = 1'b1; a2 = 16'h00FF; b2 = 16'h0000; cin2 = 1; op2 = 0;
      @(posedge clk); #1;
      start2 = 1'b0;
      cyc = 1;
      while (!done2 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("n2_lat", 64'(cyc), 64'd3);
      chk("n2_sum", 64'(sum2), 64'h0100);
      chk("n2_cout", 64'(cout2), 64'd0);
      chk("n2_rdy", 64'(ready2), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
